sa_operand_feeder: RTL

//  Hardware source for the systolic array's West/North operand edges. Holds KxK

---
 rtl/sa_pkg.sv | 26 ++
 rtl/sa_operand_buf.sv | 48 ++++
 rtl/sa_operand_feeder.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/sa_pkg.sv
// Shared types and default sizing for the systolic-array operand feeder.
// Modules derive their own widths from their N parameter; the defaults here describe the stock N=4 array.
package sa_pkg;

    localparam int SA_N       = 4;
    localparam int SA_WDATA   = 4;
    localparam int SA_TIMEOUT = 64;

    localparam int KW = $clog2(SA_N + 1);
    localparam int IW = $clog2(SA_N);
    localparam int TW = $clog2(2 * SA_N);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_FLUSH,
        ST_WAIT,
        ST_DONE
    } feeder_state_e;

    function automatic logic k_in_range(input int k, input int n);
        return (k >= 1) && (k <= n);
    endfunction

endpackage

// File: rtl/sa_operand_buf.sv
// NxN operand store with one write port and N skewed combinational read lanes.
// NORTH=0 reads lane i as M[i][step-i] (West edge); NORTH=1 reads M[step-i][i] (North edge).
module sa_operand_buf
    import sa_pkg::*;
#(
    parameter int N     = SA_N,
    parameter int WDATA = SA_WDATA,
    parameter bit NORTH = 1'b0
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [$clog2(N)-1:0]      wr_row,
    input  logic [$clog2(N)-1:0]      wr_col,
    input  logic [WDATA-1:0]          wr_data,
    input  logic                      en,
    input  logic [$clog2(N+1)-1:0]    k,
    input  logic [$clog2(2*N)-1:0]    step,
    output logic [N*WDATA-1:0]        lanes
);

    localparam int IDX_W = $clog2(N);

    logic [WDATA-1:0] mem [N][N];
    int               d;

    // NOTE: the operand array is deliberately not reset, so loaded matrices survive rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_row][wr_col] <= wr_data;
        end
    end

    always_comb begin
        lanes = '0;
        d     = 0;
        for (int i = 0; i < N; i++) begin
            d = int'(step) - i;
            if (en && (i < int'(k)) && (d >= 0) && (d < int'(k))) begin
                if (NORTH) begin
                    lanes[i*WDATA +: WDATA] = mem[IDX_W'(d)][IDX_W'(i)];
                end else begin
                    lanes[i*WDATA +: WDATA] = mem[IDX_W'(i)][IDX_W'(d)];
                end
            end
        end
    end

endmodule

// File: rtl/sa_operand_feeder.sv
// Streams buffered KxK matrices A and B into a systolic array in diagonal-skewed order,
// then flushes, waits for the array's valid and reports completion.
module sa_operand_feeder
    import sa_pkg::*;
#(
    parameter int N       = SA_N,
    parameter int WDATA   = SA_WDATA,
    parameter int TIMEOUT = SA_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic                      wr_sel,
    input  logic [$clog2(N)-1:0]      wr_row,
    input  logic [$clog2(N)-1:0]      wr_col,
    input  logic [WDATA-1:0]          wr_data,
    output logic                      wr_ready,
    input  logic                      start,
    input  logic [$clog2(N+1)-1:0]    cfg_k,
    output logic [N*WDATA-1:0]        matrix_W,
    output logic [N*WDATA-1:0]        matrix_N,
    output logic [$clog2(N+1)-1:0]    row_cfg,
    output logic [$clog2(N+1)-1:0]    col_cfg,
    output logic                      sa_clr,
    input  logic                      sa_valid,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int CFG_W  = $clog2(N + 1);
    localparam int STEP_W = $clog2(2 * N);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    feeder_state_e       state, state_nx;
    logic [CFG_W-1:0]    k_q, k_nx;
    logic [STEP_W-1:0]   step_q, step_nx;
    logic [WAIT_W-1:0]   wait_q, wait_nx;
    logic                err_nx;
    logic                stream_nx;
    logic [N*WDATA-1:0]  w_lanes, n_lanes;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_nx = state;
        k_nx     = k_q;
        step_nx  = step_q;
        wait_nx  = wait_q;
        err_nx   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (k_in_range(int'(cfg_k), N)) begin
                        k_nx     = cfg_k;
                        state_nx = ST_CLEAR;
                    end else begin
                        state_nx = ST_DONE;
                        err_nx   = 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                state_nx = ST_STREAM;
                step_nx  = '0;
            end
            ST_STREAM: begin
                if (int'(step_q) == 2 * int'(k_q) - 2) begin
                    state_nx = ST_FLUSH;
                    step_nx  = '0;
                end else begin
                    step_nx = step_q + STEP_W'(1);
                end
            end
            ST_FLUSH: begin
                if (int'(step_q) == int'(k_q) - 1) begin
                    state_nx = ST_WAIT;
                    wait_nx  = '0;
                end else begin
                    step_nx = step_q + STEP_W'(1);
                end
            end
            ST_WAIT: begin
                if (sa_valid) begin
                    state_nx = ST_DONE;
                end else if (int'(wait_q) == TIMEOUT - 1) begin
                    state_nx = ST_DONE;
                    err_nx   = 1'b1;
                end else begin
                    wait_nx = wait_q + WAIT_W'(1);
                end
            end
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Lanes are computed for the upcoming state so the registered outputs show step t in the t-th STREAM cycle.
    assign stream_nx = (state_nx == ST_STREAM);

    sa_operand_buf #(.N(N), .WDATA(WDATA), .NORTH(1'b0)) u_buf_a (
        .clk     (clk),
        .wr_en   (wr_en && (state == ST_IDLE) && !wr_sel),
        .wr_row  (wr_row),
        .wr_col  (wr_col),
        .wr_data (wr_data),
        .en      (stream_nx),
        .k       (k_nx),
        .step    (step_nx),
        .lanes   (w_lanes)
    );

    sa_operand_buf #(.N(N), .WDATA(WDATA), .NORTH(1'b1)) u_buf_b (
        .clk     (clk),
        .wr_en   (wr_en && (state == ST_IDLE) && wr_sel),
        .wr_row  (wr_row),
        .wr_col  (wr_col),
        .wr_data (wr_data),
        .en      (stream_nx),
        .k       (k_nx),
        .step    (step_nx),
        .lanes   (n_lanes)
    );

    // NOTE: non-blocking assignments make every register sample pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            k_q      <= CFG_W'(N);
            step_q   <= '0;
            wait_q   <= '0;
            matrix_W <= '0;
            matrix_N <= '0;
            sa_clr   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
            wr_ready <= 1'b1;
        end else begin
            state    <= state_nx;
            k_q      <= k_nx;
            step_q   <= step_nx;
            wait_q   <= wait_nx;
            matrix_W <= w_lanes;
            matrix_N <= n_lanes;
            sa_clr   <= (state_nx == ST_CLEAR);
            done     <= (state_nx == ST_DONE);
            err      <= err_nx;
            busy     <= (state_nx != ST_IDLE);
            wr_ready <= (state_nx == ST_IDLE);
        end
    end

    assign row_cfg = k_q;
    assign col_cfg = k_q;

endmodule
